// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Multi-cycle MIPS-subset control FSM owning the instruction
//            register, with retired-instruction counter, memory watchdog
//            and illegal-opcode trap. Define CTRL_BNE_EN to decode bne.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int INSTR_W  = 32,
    parameter int ALU_OP_W = 6,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INSTR_W-1:0]  mem_rdata,
    input  logic                mem_ready,
    input  logic                alu_zero,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic [INSTR_W-1:0]  ir,
    output logic                ir_we,
    output logic                pc_we,
    output logic                reg_wr,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          d1,
    output logic                d2,
    output logic                d3,
    output logic                d4,
    output logic                illegal,
    output logic                timeout,
    output logic [CNT_W-1:0]    instr_count,
    output logic [3:0]          state
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_WB_R     = 4'd10,
        S_WB_I     = 4'd11,
        S_WB_MEM   = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
`ifdef CTRL_BNE_EN
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
`endif
    localparam logic [ALU_OP_W-1:0] c_ALU_ADD = ALU_OP_W'(6'b100000);
    localparam logic [ALU_OP_W-1:0] c_ALU_SUB = ALU_OP_W'(6'b100010);

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q;
    logic [CNT_W-1:0]   count_q;
    logic               timeout_q;
    logic               w_wdog_trip;
    logic               w_retire;
    logic [5:0]         w_opcode;

    assign w_opcode = ir_q[INSTR_W-1 -: 6];

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        iord    = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        reg_wr  = 1'b0;
        alu_op  = '0;
        d1      = 2'b00;
        d2      = 1'b0;
        d3      = 1'b0;
        d4      = 1'b0;
        illegal = 1'b0;
        timeout = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (w_wdog_trip) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                case (w_opcode)
                    c_OP_RTYPE:      state_d = S_EXEC_R;
                    c_OP_ADDI:       state_d = S_EXEC_I;
                    c_OP_LW, c_OP_SW: state_d = S_MEM_ADDR;
                    c_OP_BEQ:        state_d = S_BRANCH;
`ifdef CTRL_BNE_EN
                    c_OP_BNE:        state_d = S_BRANCH;
`endif
                    c_OP_J:          state_d = S_JUMP;
                    default:         state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                alu_op  = ALU_OP_W'(ir_q[5:0]);
                state_d = S_WB_R;
            end
            S_EXEC_I: begin
                alu_op  = c_ALU_ADD;
                d2      = 1'b1;
                state_d = S_WB_I;
            end
            S_MEM_ADDR: begin
                alu_op  = c_ALU_ADD;
                d2      = 1'b1;
                state_d = (w_opcode == c_OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready)        state_d = S_WB_MEM;
                else if (w_wdog_trip) state_d = S_TRAP;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready)        state_d = S_FETCH;
                else if (w_wdog_trip) state_d = S_TRAP;
            end
            S_BRANCH: begin
                alu_op  = c_ALU_SUB;
                d1      = 2'b01;
`ifdef CTRL_BNE_EN
                pc_we   = (w_opcode == c_OP_BNE) ? ~alu_zero : alu_zero;
`else
                pc_we   = alu_zero;
`endif
                state_d = S_FETCH;
            end
            S_JUMP: begin
                d1      = 2'b11;
                pc_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_WB_R: begin
                reg_wr  = 1'b1;
                d3      = 1'b1;
                state_d = S_FETCH;
            end
            S_WB_I: begin
                reg_wr  = 1'b1;
                state_d = S_FETCH;
            end
            S_WB_MEM: begin
                reg_wr  = 1'b1;
                d4      = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                illegal = ~timeout_q;
                timeout = timeout_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // An instruction retires on its return to FETCH; entry from IDLE does not count.
    assign w_retire = (state_d == S_FETCH) &&
                      (state_q inside {S_MEM_WR, S_BRANCH, S_JUMP, S_WB_R, S_WB_I, S_WB_MEM});

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ir_we)       ir_q      <= mem_rdata;
            if (w_retire)    count_q   <= count_q + CNT_W'(1);
            if (w_wdog_trip) timeout_q <= 1'b1;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_wdog
            localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            logic [WAIT_W-1:0] wait_q, wait_d;
            logic              w_waiting;

            assign w_waiting   = (state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR}) && !mem_ready;
            // Trips on the wait cycle that would make the count reach TIMEOUT.
            assign w_wdog_trip = w_waiting && (wait_q == WAIT_W'(TIMEOUT - 1));

            always_comb begin
                wait_d = wait_q;
                if (state_d != state_q) wait_d = '0;
                else if (w_waiting)     wait_d = wait_q + WAIT_W'(1);
            end

            always_ff @(posedge clk) begin
                if (!rst) wait_q <= '0;
                else      wait_q <= wait_d;
            end
        end else begin : g_no_wdog
            assign w_wdog_trip = 1'b0;
        end
    endgenerate

    assign ir          = ir_q;
    assign instr_count = count_q;
    assign state       = state_q;

endmodule
`default_nettype wire
